// File: rtl/board_mem_sched_pkg.sv
// Shared constants and types for the board memory scheduler: XVGA timing,
// memory geometry and the generation sequencing states.
package board_mem_sched_pkg;

   localparam int SCREEN_WIDTH  = 1024;
   localparam int SCREEN_HEIGHT = 768;
   localparam int H_TOTAL       = 1344;
   localparam int V_TOTAL       = 806;

   localparam int LOG_MAX_ADDR  = 16;
   localparam int WORD_SIZE     = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      UPDATING,
      SWAP
   } gen_state_t;

endpackage

// File: rtl/board_mem_sched_read_port_arbiter.sv
// Shares the single BRAM read port: render owns it inside the render window,
// the updater gets every other cycle it asks for, tagged by a valid pipe.
module read_port_arbiter
   import board_mem_sched_pkg::*;
#(
   parameter int ADDR_W       = LOG_MAX_ADDR,
   parameter int READ_LATENCY = 2,
   parameter int PREFETCH     = 4
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [10:0]       hcount_in,
   input  logic [9:0]        vcount_in,
   input  logic [ADDR_W-1:0] render_addr_in,
   input  logic              upd_req_in,
   input  logic [ADDR_W-1:0] upd_addr_in,
   output logic              upd_gnt_out,
   output logic              upd_valid_out,
   output logic [ADDR_W-1:0] mem_addr_out
);

   localparam logic [10:0] H_VIS  = 11'(SCREEN_WIDTH);
   localparam logic [10:0] H_PRE  = 11'(H_TOTAL - PREFETCH);
   localparam logic [9:0]  V_VIS  = 10'(SCREEN_HEIGHT);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

   logic                  rwin;
   logic                  pre_h;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [READ_LATENCY:0] vld_q, vld_d;

   // The prefetch tail of the last blanking line feeds the first visible line.
   assign pre_h = (hcount_in >= H_PRE);
   assign rwin  = ((vcount_in < V_VIS) && ((hcount_in < H_VIS) || pre_h)) ||
                  ((vcount_in == V_LAST) && pre_h);

   assign upd_gnt_out = upd_req_in && !rwin;

   always_comb begin
      addr_d = upd_gnt_out ? upd_addr_in : render_addr_in;
      vld_d  = {vld_q[READ_LATENCY-1:0], upd_gnt_out};
   end

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         addr_q <= '0;
         vld_q  <= '0;
      end else begin
         addr_q <= addr_d;
         vld_q  <= vld_d;
      end
   end

   assign mem_addr_out  = addr_q;
   assign upd_valid_out = vld_q[READ_LATENCY];

endmodule

// File: rtl/board_mem_sched.sv
// Board memory read-port scheduler and generation sequencer: arbitrates the
// BRAM between render and updater, starts generations, flips the display buffer.
module board_mem_sched
   import board_mem_sched_pkg::*;
#(
   parameter int LOG_MAX_ADDR = board_mem_sched_pkg::LOG_MAX_ADDR,
   parameter int WORD_SIZE    = board_mem_sched_pkg::WORD_SIZE,
   parameter int READ_LATENCY = 2,
   parameter int PREFETCH     = 4,
   parameter int GEN_PERIOD   = 8
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [10:0]             hcount_in,
   input  logic [9:0]              vcount_in,
   input  logic [LOG_MAX_ADDR-1:0] render_addr_in,
   output logic [WORD_SIZE-1:0]    render_data_out,
   input  logic                    upd_req_in,
   input  logic [LOG_MAX_ADDR-1:0] upd_addr_in,
   output logic                    upd_gnt_out,
   output logic                    upd_valid_out,
   output logic [WORD_SIZE-1:0]    upd_data_out,
   output logic [LOG_MAX_ADDR-1:0] mem_addr_out,
   input  logic [WORD_SIZE-1:0]    mem_data_in,
   input  logic                    run_in,
   input  logic                    step_in,
   output logic                    upd_start_out,
   input  logic                    upd_done_in,
   output logic                    buf_sel_out,
   output logic                    busy_out
);

   localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [7:0]  GP_LAST = 8'(GEN_PERIOD - 1);

   gen_state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       step_q, step_d;
   logic       buf_sel_q, buf_sel_d;
   logic       ftick;
   logic       start;

   read_port_arbiter #(
      .ADDR_W       (LOG_MAX_ADDR),
      .READ_LATENCY (READ_LATENCY),
      .PREFETCH     (PREFETCH)
   ) u_arb (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .hcount_in      (hcount_in),
      .vcount_in      (vcount_in),
      .render_addr_in (render_addr_in),
      .upd_req_in     (upd_req_in),
      .upd_addr_in    (upd_addr_in),
      .upd_gnt_out    (upd_gnt_out),
      .upd_valid_out  (upd_valid_out),
      .mem_addr_out   (mem_addr_out)
   );

   assign render_data_out = mem_data_in;
   assign upd_data_out    = upd_valid_out ? mem_data_in : '0;
   assign ftick           = (hcount_in == H_LAST) && (vcount_in == V_LAST);

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      step_d    = step_q || step_in;
      buf_sel_d = buf_sel_q;
      start     = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (run_in || step_q) state_d = WAIT;
         end
         WAIT: begin
            if (!run_in && !step_q) begin
               state_d = IDLE;
            end else if (ftick) begin
               if (step_q || (run_in && cnt_q == GP_LAST)) begin
                  start   = 1'b1;
                  state_d = UPDATING;
                  cnt_d   = '0;
                  step_d  = step_in;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         UPDATING: begin
            if (upd_done_in) state_d = SWAP;
         end
         SWAP: begin
            // The display buffer only ever flips at the frame boundary.
            if (ftick) begin
               buf_sel_d = !buf_sel_q;
               cnt_d     = '0;
               state_d   = run_in ? WAIT : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         step_q    <= 1'b0;
         buf_sel_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         step_q    <= step_d;
         buf_sel_q <= buf_sel_d;
      end
   end

   assign upd_start_out = start;
   assign buf_sel_out   = buf_sel_q;
   assign busy_out      = (state_q == UPDATING);

endmodule

// File: tb/tb_board_mem_sched.sv
// Scoreboard bench for board_mem_sched: grants push expected read data, a
// monitor pops on every upd_valid_out and checks data and latency.
module tb_board_mem_sched;

   localparam int RL = 2;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [10:0] hcount = '0;
   logic [9:0]  vcount = '0;
   logic [15:0] render_addr = '0;
   logic [31:0] render_data;
   logic        upd_req = 1'b0;
   logic [15:0] upd_addr = '0;
   logic        upd_gnt;
   logic        upd_valid;
   logic [31:0] upd_data;
   logic [15:0] mem_addr;
   logic [31:0] mem_data;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic        upd_start;
   logic        upd_done = 1'b0;
   logic        buf_sel;
   logic        busy;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   start_cnt = 0;
   logic bsel_tick;
   exp_t sb[$];

   logic [15:0] bram_pipe [RL] = '{default: '0};

   board_mem_sched dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .hcount_in       (hcount),
      .vcount_in       (vcount),
      .render_addr_in  (render_addr),
      .render_data_out (render_data),
      .upd_req_in      (upd_req),
      .upd_addr_in     (upd_addr),
      .upd_gnt_out     (upd_gnt),
      .upd_valid_out   (upd_valid),
      .upd_data_out    (upd_data),
      .mem_addr_out    (mem_addr),
      .mem_data_in     (mem_data),
      .run_in          (run),
      .step_in         (step),
      .upd_start_out   (upd_start),
      .upd_done_in     (upd_done),
      .buf_sel_out     (buf_sel),
      .busy_out        (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [15:0] a);
      return 32'hDEADBEEF ^ {16'h0000, a ^ 16'h0123};
   endfunction

   // BRAM model with READ_LATENCY cycles from registered address to data.
   always @(posedge clk) begin
      bram_pipe[0] <= mem_addr;
      for (int i = 1; i < RL; i++) bram_pipe[i] <= bram_pipe[i-1];
   end
   assign mem_data = model(bram_pipe[RL-1]);

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (upd_start) start_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (upd_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'(upd_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("upd_data", upd_data, e.data);
            check("valid_latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic req_cycle(input logic [10:0] h, input logic [9:0] v,
                            input logic [15:0] a, input logic exp_gnt, input bit track);
      exp_t e;
      hcount  = h;
      vcount  = v;
      upd_req = 1'b1;
      upd_addr = a;
      smp();
      check($sformatf("gnt_h%0d_v%0d", h, v), 32'(upd_gnt), 32'(exp_gnt));
      if (track && exp_gnt) begin
         e.due  = cyc + 1 + RL;
         e.data = model(a);
         sb.push_back(e);
      end
      next();
      upd_req = 1'b0;
   endtask

   // One abbreviated frame: mid cycles away from the frame end, then the ftick.
   task automatic frame(input int mid, input bit done_mid);
      hcount = 11'd500;
      vcount = 10'd500;
      for (int i = 0; i < mid; i++) begin
         upd_done = done_mid && (i == mid / 2);
         next();
      end
      upd_done = 1'b0;
      hcount = 11'd1343;
      vcount = 10'd805;
      smp();
      bsel_tick = buf_sel;
      next();
      hcount = 11'd500;
      vcount = 10'd500;
   endtask

   task automatic pulse_step();
      step = 1'b1;
      next();
      step = 1'b0;
   endtask

   typedef struct {
      logic [10:0] h;
      logic [9:0]  v;
      logic        gnt;
   } win_vec_t;

   win_vec_t wv[9] = '{
      '{11'd1339, 10'd10,  1'b1},
      '{11'd1340, 10'd10,  1'b0},
      '{11'd1343, 10'd10,  1'b0},
      '{11'd1023, 10'd10,  1'b0},
      '{11'd1024, 10'd10,  1'b1},
      '{11'd100,  10'd768, 1'b1},
      '{11'd1340, 10'd805, 1'b0},
      '{11'd1339, 10'd805, 1'b1},
      '{11'd1030, 10'd767, 1'b1}
   };

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rst = 1'b1;
      hcount = 11'd100;
      vcount = 10'd10;
      repeat (3) next();
      rst = 1'b0;
      smp();
      check("rst_gnt", 32'(upd_gnt), 32'd0);
      check("rst_valid", 32'(upd_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bufsel", 32'(buf_sel), 32'd0);
      check("rst_start", 32'(upd_start), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      next();

      // Render owns the port inside the visible area
      render_addr = 16'h0AAA;
      req_cycle(11'd100, 10'd10, 16'h0555, 1'b0, 1'b1);
      smp();
      check("mem_addr_render", 32'(mem_addr), 32'h0AAA);
      next();
      repeat (3) next();
      smp();
      check("render_data", render_data, model(16'h0AAA));
      next();

      // Updater grant in horizontal blanking, data returns 1+RL cycles later
      req_cycle(11'd1030, 10'd10, 16'h0123, 1'b1, 1'b1);
      smp();
      check("mem_addr_upd", 32'(mem_addr), 32'h0123);
      next();
      repeat (5) next();

      // Window edges: prefetch, visible boundary, vblank, first-line prefetch
      for (int i = 0; i < 9; i++)
         req_cycle(wv[i].h, wv[i].v, 16'h1000 + 16'(i), wv[i].gnt, 1'b1);
      repeat (6) next();

      // Free-running generations
      run = 1'b1;
      next();
      for (int f = 1; f <= 7; f++) frame(3, 1'b0);
      check("run_no_early_start", 32'(start_cnt), 32'd0);
      frame(3, 1'b0);
      check("run_start_frame8", 32'(start_cnt), 32'd1);
      smp();
      check("run_busy", 32'(busy), 32'd1);
      next();
      frame(3, 1'b0);
      check("run_bufsel_f9", 32'(bsel_tick), 32'd0);
      frame(4, 1'b1);
      check("run_bufsel_at_tick", 32'(bsel_tick), 32'd0);
      smp();
      check("run_bufsel_after_tick", 32'(buf_sel), 32'd1);
      check("run_busy_after_swap", 32'(busy), 32'd0);
      next();
      run = 1'b0;
      repeat (2) next();
      smp();
      check("run_stop_busy", 32'(busy), 32'd0);
      next();

      // Single steps; two pulses during UPDATING coalesce to one generation
      pulse_step();
      frame(3, 1'b0);
      check("step_start1", 32'(start_cnt), 32'd2);
      smp();
      check("step_busy1", 32'(busy), 32'd1);
      next();
      pulse_step();
      next();
      pulse_step();
      frame(4, 1'b1);
      smp();
      check("step_bufsel1", 32'(buf_sel), 32'd0);
      next();
      frame(3, 1'b0);
      check("step_start2", 32'(start_cnt), 32'd3);
      frame(4, 1'b1);
      smp();
      check("step_bufsel2", 32'(buf_sel), 32'd1);
      next();
      frame(3, 1'b0);
      frame(3, 1'b0);
      check("step_no_extra_start", 32'(start_cnt), 32'd3);
      smp();
      check("step_idle_busy", 32'(busy), 32'd0);
      next();

      // Reset during a generation with two grants in flight
      pulse_step();
      frame(3, 1'b0);
      check("rst_gen_start", 32'(start_cnt), 32'd4);
      req_cycle(11'd1030, 10'd10, 16'h0777, 1'b1, 1'b0);
      req_cycle(11'd1030, 10'd10, 16'h0778, 1'b1, 1'b0);
      rst = 1'b1;
      sb.delete();
      next();
      rst = 1'b0;
      smp();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_bufsel", 32'(buf_sel), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("midrst_valid_%0d", i), 32'(upd_valid), 32'd0);
         next();
         smp();
      end
      next();

      repeat (4) next();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
